mem_write_buffer: RTL

//   Posted write buffer directly downstream of mem_cache. Absorbs cache write-throughs
//   (address/data pairs) into a small FIFO and drains them to backing memory over a
//   req/ack handshake. Read lookups check the buffer, so the cache never returns data

---
 rtl/mem_write_buffer_pkg.sv | 9 +
 rtl/mem_write_buffer_if.sv | 24 ++
 rtl/mem_write_buffer_match.sv | 26 ++
 rtl/mem_write_buffer.sv | 72 +++++++
 4 files changed

// File: rtl/mem_write_buffer_pkg.sv
// mem_write_buffer_pkg: widths, depth and drain FSM states shared by the write buffer slice.
package mem_write_buffer_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  typedef enum logic {WB_IDLE = 1'b0, WB_REQ = 1'b1} wbState_t;
endpackage

// File: rtl/mem_write_buffer_if.sv
// mem_write_buffer_if: cache-side write/lookup and memory-side drain signals of the write buffer.
interface mem_write_buffer_if;
  import mem_write_buffer_pkg::*;
  logic write;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic full;
  logic empty;
  logic [ADDR_W-1:0] readAddr;
  logic fwdHit;
  logic [DATA_W-1:0] fwdData;
  logic memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic memAck;
  modport slave (
    input write, writeAddr, writeData, readAddr, memAck,
    output full, empty, fwdHit, fwdData, memReq, memAddr, memData
  );
  modport master (
    output write, writeAddr, writeData, readAddr, memAck,
    input full, empty, fwdHit, fwdData, memReq, memAddr, memData
  );
endinterface

// File: rtl/mem_write_buffer_match.sv
// mem_write_buffer_match: DEPTH-way address compare, youngest (nearest tail) match wins.
module mem_write_buffer_match
  import mem_write_buffer_pkg::*;
(
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);
  logic [PTR_W-1:0] slot;
  // Walk from head towards tail so a later match overrides an older one.
  always_comb begin
    hit = 1'b0;
    idx = head;
    slot = head;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (valid[slot] && addrs[slot] == addr) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end
endmodule

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted write FIFO with coalescing, read forwarding and a req/ack drain FSM.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
(
  input logic clk,
  input logic reset,
  mem_write_buffer_if.slave bus
);
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0] valid, wrMask;
  logic [PTR_W-1:0] head, tail, fwdIdx, wrIdx;
  logic [PTR_W:0] count;
  wbState_t state;
  logic fwdHit, wrHit, full, coalesce, alloc, pop, start;
  logic memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  // The head being drained is frozen: a same-address write must allocate a new entry.
  assign wrMask = valid & ~((state == WB_REQ) ? DEPTH'(1) << head : '0);
  assign full = count == FULL_COUNT;
  assign coalesce = bus.write && wrHit;
  assign alloc = bus.write && !wrHit && !full;
  assign pop = state == WB_REQ && bus.memAck;
  assign start = state == WB_IDLE && count != '0;
  mem_write_buffer_match uFwd (
    .valid(valid), .addrs(addrMem), .head(head), .addr(bus.readAddr), .hit(fwdHit), .idx(fwdIdx)
  );
  mem_write_buffer_match uWr (
    .valid(wrMask), .addrs(addrMem), .head(head), .addr(bus.writeAddr), .hit(wrHit), .idx(wrIdx)
  );
  assign bus.full = full;
  assign bus.empty = count == '0 && state == WB_IDLE;
  assign bus.fwdHit = fwdHit;
  assign bus.fwdData = fwdHit ? dataMem[fwdIdx] : '0;
  assign bus.memReq = memReq;
  assign bus.memAddr = memAddr;
  assign bus.memData = memData;
  always_ff @(posedge clk) begin
    if (coalesce) dataMem[wrIdx] <= bus.writeData;
    if (alloc) begin
      addrMem[tail] <= bus.writeAddr;
      dataMem[tail] <= bus.writeData;
    end
  end
  // A write coalescing into the head on the latch edge must reach memory, so bypass it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= WB_IDLE;
      memReq <= 1'b0;
      memAddr <= '0;
      memData <= '0;
    end else begin
      valid <= (valid | (alloc ? DEPTH'(1) << tail : '0)) & ~(pop ? DEPTH'(1) << head : '0);
      if (alloc) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};
      if (start) begin
        state <= WB_REQ;
        memReq <= 1'b1;
        memAddr <= addrMem[head];
        memData <= (coalesce && wrIdx == head) ? bus.writeData : dataMem[head];
      end else if (pop) begin
        state <= WB_IDLE;
        memReq <= 1'b0;
      end
    end
endmodule
